// File: rtl/bf8b_pkg.sv
// Shared definitions for the bf8b core: opcode constants, fetch state encoding, width defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bf8b_pkg;

    // Default datapath widths for the fetch stage
    localparam int DEF_M_WIDTH    = 8;
    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;

    // Major opcodes seen by decode (low 7 bits of the instruction word)
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_INTEGER = 7'b0110011;

    // Fetch controller state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// Instruction fetch: reads INST_WIDTH/M_WIDTH bytes from pc upward, assembles them little-endian. Optional FETCH_ALIGN_CHECK_EN faults misaligned pc.
// Latency: NBEATS+1 cycles from en to the ready pulse with zero-wait memory; next en sampled one cycle after ready.
// Backpressure: mem_ready=0 stalls a beat indefinitely with mem_rd_en/mem_addr held; en and pc are ignored while busy.
module fetch
    import bf8b_pkg::*;
#(
    parameter int M_WIDTH    = DEF_M_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [M_WIDTH-1:0]    mem_data_in,
    input  logic                  mem_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  ready,
    output logic                  busy,
    output logic                  fault
);

    localparam int NBEATS = INST_WIDTH / M_WIDTH;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic [INST_WIDTH-1:0] asm_word;
    logic [INST_WIDTH-1:0] asm_nxt;
    logic                  misaligned;
    logic                  start;
    logic                  beat;
    logic                  last_beat;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] NB_A = ADDR_WIDTH'(NBEATS);
    assign misaligned = (pc % NB_A) != '0;
`else
    assign misaligned = 1'b0;
`endif

    // mem_rd_en is high for the whole of FETCH, so a beat is just FETCH & mem_ready
    assign start     = (state == IDLE) && en && !misaligned;
    assign beat      = (state == FETCH) && mem_ready;
    assign last_beat = beat && (cnt == LAST_CNT);

    // Merge the arriving beat into the partial word at its little-endian slot
    always_comb begin
        asm_nxt = asm_word;
        asm_nxt[int'(cnt) * M_WIDTH +: M_WIDTH] = mem_data_in;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state == FETCH) || (state == DONE);
    end

    // Datapath: request address sequencing, beat capture, and word publication
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            base      <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            asm_word  <= '0;
            inst      <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= last_beat;
            if (start) begin
                base      <= pc;
                cnt       <= '0;
                mem_addr  <= pc;
                mem_rd_en <= 1'b1;
            end
            if (beat) begin
                asm_word <= asm_nxt;
                if (last_beat) begin
                    inst      <= asm_nxt;
                    mem_rd_en <= 1'b0;
                end else begin
                    cnt      <= cnt + 1'b1;
                    mem_addr <= base + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(1);
                end
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Single-cycle fault pulse for a misaligned start request; no access is made
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= (state == IDLE) && en && misaligned;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule
